// File: rtl/packet_fifo_pkg.sv
// Shared definitions for the multi-channel packet buffer: default packet
// width, a constant-evaluable ceil(log2) and the flat-bus slice helper.
package packet_fifo_pkg;

  localparam int PACKET_WIDTH_DEF = 128;

  // ceil(log2(value)); usable in parameter and localparam expressions
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Low bit of element idx in a flat bus of width-bit elements
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/packet_fifo_mc_if.sv
// Bundle of the producer-side, status and consumer-side signals of the
// multi-channel packet buffer. The buffer itself uses the slave view.
interface packet_fifo_mc_if
  import packet_fifo_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int DEPTH        = 8,
  parameter int NUM_CH       = 4
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(NUM_CH);

  logic [NUM_CH-1:0]              wr_en;
  logic [NUM_CH*PACKET_WIDTH-1:0] wr_data;
  logic [NUM_CH-1:0]              full;
  logic [NUM_CH-1:0]              almost_full;
  logic [NUM_CH-1:0]              empty;
  logic [NUM_CH*(AW+1)-1:0]       count;
  logic [NUM_CH-1:0]              overflow;
  logic                           err_clr;
  logic                           out_valid;
  logic                           out_ready;
  logic [PACKET_WIDTH-1:0]        out_data;
  logic [CW-1:0]                  out_ch;

  modport master (
    output wr_en, wr_data, err_clr, out_ready,
    input  full, almost_full, empty, count, overflow,
    input  out_valid, out_data, out_ch
  );

  modport slave (
    input  wr_en, wr_data, err_clr, out_ready,
    output full, almost_full, empty, count, overflow,
    output out_valid, out_data, out_ch
  );

endinterface

// File: rtl/packet_fifo_chan.sv
// Single-channel circular packet store. Pointers carry an extra wrap bit so
// full and empty are distinguishable; all status flags are decoded from the
// registered pointers and therefore always agree with count.
module packet_fifo_chan
  import packet_fifo_pkg::*;
#(
  parameter int  PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int  DEPTH        = 8,
  parameter int  AFULL_THRESH = 6,
  localparam int AW           = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [PACKET_WIDTH-1:0] wr_data,
  input  logic                    pop,
  input  logic                    err_clr,
  output logic [PACKET_WIDTH-1:0] rd_data,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic [AW:0]             count,
  output logic                    overflow
);

  localparam logic [AW:0] PTR_ONE   = 1;
  localparam logic [AW:0] AFULL_LVL = AFULL_THRESH[AW:0];

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    wr_ok;

  // A write is judged on pre-edge fullness; a same-cycle pop never frees room
  assign wr_ok       = wr_en && !full;
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign almost_full = (count >= AFULL_LVL);
  assign rd_data     = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted writes and on pops from the arbiter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Packet storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (err_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_fifo_mc.sv
// Multi-channel packet buffer: NUM_CH channel FIFOs drained through a
// round-robin arbiter into a single registered valid/ready output.
module packet_fifo_mc
  import packet_fifo_pkg::*;
#(
  parameter int  PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int  DEPTH        = 8,
  parameter int  NUM_CH       = 4,
  parameter int  AFULL_THRESH = 6,
  localparam int AW           = clog2(DEPTH),
  localparam int CW           = clog2(NUM_CH)
) (
  input logic             clk,
  input logic             rst,
  packet_fifo_mc_if.slave bus
);

  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  logic [PACKET_WIDTH-1:0] head [NUM_CH];
  logic [NUM_CH-1:0]       ch_empty;
  logic [NUM_CH-1:0]       pop;
  logic [CW-1:0]           last_grant;
  logic [CW-1:0]           grant;
  logic                    found;
  logic                    load;
  int                      idx;

  logic                    vld_p0;
  logic [PACKET_WIDTH-1:0] data_p0;
  logic [CW-1:0]           ch_p0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    packet_fifo_chan #(
      .PACKET_WIDTH (PACKET_WIDTH),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (bus.wr_en[c]),
      .wr_data     (bus.wr_data[slice_lo(c, PACKET_WIDTH) +: PACKET_WIDTH]),
      .pop         (pop[c]),
      .err_clr     (bus.err_clr),
      .rd_data     (head[c]),
      .empty       (ch_empty[c]),
      .full        (bus.full[c]),
      .almost_full (bus.almost_full[c]),
      .count       (bus.count[slice_lo(c, AW + 1) +: AW + 1]),
      .overflow    (bus.overflow[c])
    );
  end

  assign bus.empty     = ch_empty;
  assign bus.out_valid = vld_p0;
  assign bus.out_data  = data_p0;
  assign bus.out_ch    = ch_p0;

  // The output register may take a new packet when it is empty or being consumed
  assign load = !vld_p0 || bus.out_ready;

  // Round-robin search: first non-empty channel after last_grant, with wrap
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && !ch_empty[CW'(idx)]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end

  // One-hot pop to the granted channel whenever the output register loads
  always_comb begin
    pop = '0;
    if (load && found) pop[grant] = 1'b1;
  end

  // ---- stage p0: output register and arbiter history ----
  // Capture the granted head packet; drop valid when nothing is queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      ch_p0      <= '0;
      last_grant <= LAST_CH;
    end else if (load) begin
      vld_p0 <= found;
      if (found) begin
        data_p0    <= head[grant];
        ch_p0      <= grant;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: doc/packet_fifo_mc.md
Name: packet_fifo_mc

Overview:
Multi-channel packet buffer. NUM_CH independent per-channel FIFOs feed a single output port through a round-robin arbiter with a valid/ready handshake. Adds occupancy count, almost_full, and sticky overflow flags. Sits between the per-source packet producers and the single downstream packet consumer.

Parameters:
PACKET_WIDTH, 128, packet width in bits
DEPTH, 8, entries per channel; power of two, >=2
NUM_CH, 4, number of input channels, >=2
AFULL_THRESH, 6, almost_full[c] asserts when count[c] >= AFULL_THRESH; range 1..DEPTH
AW (localparam), clog2(DEPTH), pointer width; CW (localparam), clog2(NUM_CH), channel-index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  NUM_CH  per-channel write request
wr_data  in  NUM_CH*PACKET_WIDTH  channel c occupies bits [c*PACKET_WIDTH +: PACKET_WIDTH]
full  out  NUM_CH  channel at DEPTH entries
almost_full  out  NUM_CH  count >= AFULL_THRESH
empty  out  NUM_CH  channel holds 0 entries
count  out  NUM_CH*(AW+1)  per-channel occupancy, 0..DEPTH
overflow  out  NUM_CH  sticky: a write was attempted while full
err_clr  in  1  synchronous clear of all overflow bits
out_valid  out  1  out_data/out_ch hold a packet
out_ready  in  1  consumer accepts the packet when out_valid && out_ready
out_data  out  PACKET_WIDTH  packet
out_ch  out  CW  source channel of out_data

Behaviour:
- Reset (async, takes effect immediately): all pointers 0, count 0, empty all 1, full/almost_full/overflow 0, out_valid 0, out_data 0, out_ch 0, round-robin last_grant = NUM_CH-1 (channel 0 has highest priority first). Reset mid-operation discards all contents, including a held output packet.
- Storage: per-channel circular buffer; rd/wr pointers are AW+1 bits (extra wrap bit). full = same index and differing wrap bit. empty = pointers equal. Pointers wrap modulo DEPTH.
- Write: accepted at a posedge iff wr_en[c] && !full[c], judged on pre-edge state. A write while full is dropped, contents are unchanged, and overflow[c] is set. A same-cycle pop does not make room for a write to a full channel.
- overflow: set has priority over err_clr in the same cycle.
- Output stage: one register (out_valid/out_data/out_ch). It loads when !out_valid || out_ready. On load, the arbiter pops one non-empty channel. If no channel is non-empty, out_valid deasserts after the edge.
- Arbiter: round-robin among !empty channels, searching from last_grant+1 upward with wrap. last_grant updates only on a pop.
- Latency: write at edge k; empty deasserts after edge k; pop at edge k+1 at the earliest; out_valid is high after edge k+1. Sustained throughput is 1 packet/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, out_data and out_ch stay stable and no pop occurs.
- count: +1 on an accepted write, -1 on a pop, unchanged when both happen on one channel in the same cycle. Flags are registered-consistent with count.
- Per-channel ordering is strict FIFO. No ordering is guaranteed across channels beyond the round-robin rule.

Decomposition:
- Package packet_fifo_pkg holds: the default PACKET_WIDTH, a clog2 function, and the channel-slice helper for wr_data/count.
- Sub-module packet_fifo_chan: single-channel storage with wr_en/wr_data, pop, empty/full/almost_full/count/overflow, and the err_clr input.
- Top level: instantiates NUM_CH copies of packet_fifo_chan via generate, plus the arbiter and output register.

Test Plan:
1. Ch0 fill, out_ready=0: write 0..7 (8 writes) -> one packet pops to the output register, so count[0]=7 and full[0]=0. Write 8 -> count[0]=8, full[0]=1; almost_full[0] was set once count[0] reached 6. Write 99 -> dropped, overflow[0]=1, count unchanged. err_clr -> overflow[0]=0.
2. Drain ch0, out_ready=1 -> out_data 0..8 in order, out_ch=0, one per cycle. empty[0]=1 and count[0]=0 after the last pop, then out_valid=0.
3. Round-robin: preload ch0={10,11}, ch1={20}, ch3={40,41} with out_ready=0, then raise out_ready -> output order 10,20,40,11,41 with out_ch 0,1,3,0,3.
4. Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data and out_ch stable, all counts unchanged; release -> next packet the following cycle.
5. Wrap and simultaneous operation: stream 100..119 into ch2 with out_ready=1, holding count[2]=3 during concurrent write/pop -> count stays 3, output is 100..119 in order, no overflow.
6. Reset mid-stream: assert rst between edges with 3 packets queued -> out_valid=0, empty all 1, count 0, overflow 0 immediately. After release, write 5 on ch1 -> out_data=5, out_ch=1 two edges later.
